// File: rtl/uart_pkg.sv
// Shared register map, status bit positions, oversampling constants and FSM
// state types for the wb_uart_serial UART.
package uart_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_DIV    = 2'd3;

  localparam int ST_RX_VALID   = 0;
  localparam int ST_RX_OVERRUN = 1;
  localparam int ST_TX_READY   = 2;
  localparam int ST_TX_BUSY    = 3;
  localparam int ST_FRAME_ERR  = 4;

  localparam int OVERSAMPLE = 16;

  // Tick-count values marking the end of a bit and the middle of a start bit.
  localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] TICK_HALF = 4'(OVERSAMPLE / 2 - 1);

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

endpackage

// File: rtl/uart_rx_frame.sv
// Receive framer: synchronises rxd, hunts for a start bit and shifts in one
// 8N1 frame, reporting a one-clock strobe with the byte and stop-bit status.
module uart_rx_frame
  import uart_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       tick_i,
  input  logic       rxd_i,
  output logic [7:0] byte_o,
  output logic       byte_stb_o,
  output logic       frame_ok_o
);

  logic [1:0] sync_q;
  logic       prev_q;
  rx_state_e  state_q;
  logic [3:0] tcnt_q;
  logic [2:0] bitcnt_q;
  logic [7:0] shift_q;
  logic       stb_q;
  logic       ok_q;

  logic line;
  logic fall;

  assign line = sync_q[1];
  assign fall = prev_q & ~line;

  assign byte_o     = shift_q;
  assign byte_stb_o = stb_q;
  assign frame_ok_o = ok_q;

  // A start is confirmed only if the line is still low half a bit later.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sync_q   <= 2'b11;
      prev_q   <= 1'b1;
      state_q  <= RX_IDLE;
      tcnt_q   <= '0;
      bitcnt_q <= '0;
      shift_q  <= '0;
      stb_q    <= 1'b0;
      ok_q     <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], rxd_i};
      prev_q <= line;
      stb_q  <= 1'b0;
      case (state_q)
        RX_IDLE: begin
          if (fall) begin
            state_q <= RX_START;
            tcnt_q  <= '0;
          end
        end
        RX_START: begin
          if (tick_i) begin
            if (tcnt_q == TICK_HALF) begin
              tcnt_q   <= '0;
              bitcnt_q <= '0;
              state_q  <= line ? RX_IDLE : RX_DATA;
            end else begin
              tcnt_q <= tcnt_q + 4'd1;
            end
          end
        end
        RX_DATA: begin
          if (tick_i) begin
            tcnt_q <= tcnt_q + 4'd1;
            if (tcnt_q == TICK_LAST) begin
              shift_q  <= {line, shift_q[7:1]};
              bitcnt_q <= bitcnt_q + 3'd1;
              if (bitcnt_q == 3'd7) begin
                state_q <= RX_STOP;
              end
            end
          end
        end
        RX_STOP: begin
          if (tick_i) begin
            tcnt_q <= tcnt_q + 4'd1;
            if (tcnt_q == TICK_LAST) begin
              stb_q   <= 1'b1;
              ok_q    <= line;
              state_q <= RX_IDLE;
            end
          end
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/wb_uart_serial.sv
// Zero-wait-state bus UART: register file, tick generator, transmit path with
// holding register and shifter, and the receive framer.
module wb_uart_serial
  import uart_pkg::*;
#(
  parameter logic [7:0] DIV_RESET = 8'd26
) (
  input  logic       wb_clk_i,
  input  logic       rst_i,
  input  logic       wb_cyc_i,
  input  logic       wb_we_i,
  input  logic [1:0] wb_addr_i,
  input  logic [7:0] wb_datw_i,
  output logic [7:0] wb_datr_o,
  output logic       int_o,
  input  logic       rxd_i,
  output logic       txd_o
);

  logic       rd_data;
  logic       rd_status;
  logic       wr_data;
  logic       wr_ctrl;
  logic       wr_div;

  logic [7:0] div_q;
  logic [7:0] div_d;
  logic [1:0] ctrl_q;
  logic [1:0] ctrl_d;
  logic [7:0] tick_cnt_q;
  logic       tick;

  logic [7:0] rx_byte;
  logic       rx_stb;
  logic       rx_ok;
  logic [7:0] rx_data_q;
  logic [7:0] rx_data_d;
  logic       rx_valid_q;
  logic       rx_valid_d;
  logic       rx_overrun_q;
  logic       rx_overrun_d;
  logic       frame_err_q;
  logic       frame_err_d;

  tx_state_e  tx_state_q;
  logic [3:0] tx_tcnt_q;
  logic [2:0] tx_bit_q;
  logic [7:0] tx_shift_q;
  logic [7:0] tx_hold_q;
  logic       tx_ready_q;
  logic       tx_busy_q;
  logic       txd_q;
  logic       tx_bit_end;
  logic       tx_take;
  logic       wr_accept;

  logic [7:0] status;

  assign rd_data   = wb_cyc_i & ~wb_we_i & (wb_addr_i == ADDR_DATA);
  assign rd_status = wb_cyc_i & ~wb_we_i & (wb_addr_i == ADDR_STATUS);
  assign wr_data   = wb_cyc_i &  wb_we_i & (wb_addr_i == ADDR_DATA);
  assign wr_ctrl   = wb_cyc_i &  wb_we_i & (wb_addr_i == ADDR_CTRL);
  assign wr_div    = wb_cyc_i &  wb_we_i & (wb_addr_i == ADDR_DIV);

  assign tick = (tick_cnt_q == 8'd0);

  always_ff @(posedge wb_clk_i or negedge rst_i) begin
    if (!rst_i) begin
      tick_cnt_q <= DIV_RESET;
    end else if (wr_div) begin
      tick_cnt_q <= wb_datw_i;
    end else if (tick) begin
      tick_cnt_q <= div_q;
    end else begin
      tick_cnt_q <= tick_cnt_q - 8'd1;
    end
  end

  uart_rx_frame u_rx (
    .clk_i      (wb_clk_i),
    .rst_i      (rst_i),
    .tick_i     (tick),
    .rxd_i      (rxd_i),
    .byte_o     (rx_byte),
    .byte_stb_o (rx_stb),
    .frame_ok_o (rx_ok)
  );

  // The pop is applied before a completing frame is considered, so a read
  // racing a new byte leaves rx_valid set without an overrun.
  always_comb begin
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q & ~rd_data;
    rx_overrun_d = rx_overrun_q & ~rd_status;
    frame_err_d  = frame_err_q & ~rd_status;
    if (rx_stb) begin
      if (!rx_ok) begin
        frame_err_d = 1'b1;
      end else if (rx_valid_d) begin
        rx_overrun_d = 1'b1;
      end else begin
        rx_data_d  = rx_byte;
        rx_valid_d = 1'b1;
      end
    end
  end

  always_comb begin
    ctrl_d = wr_ctrl ? wb_datw_i[1:0] : ctrl_q;
    div_d  = wr_div  ? wb_datw_i      : div_q;
  end

  always_ff @(posedge wb_clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      rx_overrun_q <= 1'b0;
      frame_err_q  <= 1'b0;
      ctrl_q       <= 2'b01;
      div_q        <= DIV_RESET;
    end else begin
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      rx_overrun_q <= rx_overrun_d;
      frame_err_q  <= frame_err_d;
      ctrl_q       <= ctrl_d;
      div_q        <= div_d;
    end
  end

  assign tx_bit_end = tick & (tx_tcnt_q == TICK_LAST);
  assign tx_take    = ~tx_ready_q &
                      ((tx_state_q == TX_IDLE) | ((tx_state_q == TX_STOP) & tx_bit_end));
  assign wr_accept  = wr_data & (tx_ready_q | tx_take);

  // Holding register and shifter share one block so a write landing on the
  // edge the shifter empties the holding register is still accepted.
  always_ff @(posedge wb_clk_i or negedge rst_i) begin
    if (!rst_i) begin
      tx_state_q <= TX_IDLE;
      tx_tcnt_q  <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_hold_q  <= '0;
      tx_ready_q <= 1'b1;
      tx_busy_q  <= 1'b0;
      txd_q      <= 1'b1;
    end else begin
      if (wr_accept) begin
        tx_hold_q  <= wb_datw_i;
        tx_ready_q <= 1'b0;
      end else if (tx_take) begin
        tx_ready_q <= 1'b1;
      end
      case (tx_state_q)
        TX_IDLE: begin
          if (tx_take) begin
            tx_shift_q <= tx_hold_q;
            tx_busy_q  <= 1'b1;
            txd_q      <= 1'b0;
            tx_tcnt_q  <= '0;
            tx_state_q <= TX_START;
          end
        end
        TX_START: begin
          if (tick) begin
            tx_tcnt_q <= tx_tcnt_q + 4'd1;
            if (tx_bit_end) begin
              txd_q      <= tx_shift_q[0];
              tx_bit_q   <= '0;
              tx_state_q <= TX_DATA;
            end
          end
        end
        TX_DATA: begin
          if (tick) begin
            tx_tcnt_q <= tx_tcnt_q + 4'd1;
            if (tx_bit_end) begin
              if (tx_bit_q == 3'd7) begin
                txd_q      <= 1'b1;
                tx_state_q <= TX_STOP;
              end else begin
                tx_bit_q   <= tx_bit_q + 3'd1;
                tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                txd_q      <= tx_shift_q[1];
              end
            end
          end
        end
        TX_STOP: begin
          if (tick) begin
            tx_tcnt_q <= tx_tcnt_q + 4'd1;
            if (tx_bit_end) begin
              if (tx_take) begin
                tx_shift_q <= tx_hold_q;
                txd_q      <= 1'b0;
                tx_state_q <= TX_START;
              end else begin
                tx_busy_q  <= 1'b0;
                tx_state_q <= TX_IDLE;
              end
            end
          end
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

  assign txd_o = txd_q;
  assign int_o = (rx_valid_q & ctrl_q[0]) | (tx_ready_q & ctrl_q[1]);

  always_comb begin
    status                = '0;
    status[ST_RX_VALID]   = rx_valid_q;
    status[ST_RX_OVERRUN] = rx_overrun_q;
    status[ST_TX_READY]   = tx_ready_q;
    status[ST_TX_BUSY]    = tx_busy_q;
    status[ST_FRAME_ERR]  = frame_err_q;
  end

  always_comb begin
    wb_datr_o = 8'h00;
    if (wb_cyc_i) begin
      case (wb_addr_i)
        ADDR_DATA:   wb_datr_o = rx_data_q;
        ADDR_STATUS: wb_datr_o = status;
        ADDR_CTRL:   wb_datr_o = {6'b0, ctrl_q};
        default:     wb_datr_o = div_q;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_uart_serial.sv
// Directed self-checking bench for wb_uart_serial at DIV=0 (16-clock bits):
// reset, RX, TX waveform, overrun, framing error, glitch rejection and echo.
module tb_wb_uart_serial;
  import uart_pkg::*;

  logic       clock = 1'b0;
  logic       resetN;
  logic       wbCyc;
  logic       wbWe;
  logic [1:0] wbAddr;
  logic [7:0] wbDatw;
  logic [7:0] wbDatr;
  logic       intO;
  logic       rxd;
  logic       txd;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  wb_uart_serial #(.DIV_RESET(8'd26)) dut (
    .wb_clk_i  (clock),
    .rst_i     (resetN),
    .wb_cyc_i  (wbCyc),
    .wb_we_i   (wbWe),
    .wb_addr_i (wbAddr),
    .wb_datw_i (wbDatw),
    .wb_datr_o (wbDatr),
    .int_o     (intO),
    .rxd_i     (rxd),
    .txd_o     (txd)
  );

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%02h expected=0x%02h", tag, observed, expected);
    end
  endtask

  // One bus access: driven mid-cycle, read data sampled before the edge.
  task automatic applyStimulus(input logic we, input logic [1:0] addr,
                               input logic [7:0] wdat, output logic [7:0] rdat);
    @(negedge clock);
    wbCyc  = 1'b1;
    wbWe   = we;
    wbAddr = addr;
    wbDatw = wdat;
    #1 rdat = wbDatr;
    @(posedge clock);
    #1;
    wbCyc = 1'b0;
    wbWe  = 1'b0;
  endtask

  task automatic readReg(input logic [1:0] addr, output logic [7:0] value);
    applyStimulus(1'b0, addr, 8'h00, value);
  endtask

  task automatic writeReg(input logic [1:0] addr, input logic [7:0] value);
    logic [7:0] unused;
    applyStimulus(1'b1, addr, value, unused);
  endtask

  task automatic sendSerial(input logic [7:0] data, input logic stopBit);
    @(negedge clock);
    rxd = 1'b0;
    repeat (16) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rxd = data[i];
      repeat (16) @(negedge clock);
    end
    rxd = stopBit;
    repeat (16) @(negedge clock);
    rxd = 1'b1;
  endtask

  task automatic captureTx(output logic [7:0] data, output logic found);
    int waited = 0;
    data  = '0;
    found = 1'b0;
    while (txd !== 1'b0 && waited < 2000) begin
      @(negedge clock);
      waited++;
    end
    if (txd === 1'b0) begin
      found = 1'b1;
      repeat (8) @(negedge clock);
      checkOutput("echoTxStart", {7'b0, txd}, 8'h00);
      for (int i = 0; i < 8; i++) begin
        repeat (16) @(negedge clock);
        data[i] = txd;
      end
      repeat (16) @(negedge clock);
      checkOutput("echoTxStop", {7'b0, txd}, 8'h01);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] r;
    logic [9:0] txPattern;
    txPattern = 10'b1101001010;
    resetN = 1'b0;
    wbCyc  = 1'b0;
    wbWe   = 1'b0;
    wbAddr = 2'd0;
    wbDatw = 8'h00;
    rxd    = 1'b1;

    repeat (3) @(negedge clock);
    checkOutput("resetTxd", {7'b0, txd}, 8'h01);
    checkOutput("resetInt", {7'b0, intO}, 8'h00);
    checkOutput("resetDatr", wbDatr, 8'h00);
    resetN = 1'b1;
    readReg(ADDR_STATUS, r); checkOutput("resetStatus", r, 8'h04);
    readReg(ADDR_CTRL, r);   checkOutput("resetCtrl", r, 8'h01);
    readReg(ADDR_DIV, r);    checkOutput("resetDiv", r, 8'h1A);
    writeReg(ADDR_DIV, 8'h00);
    readReg(ADDR_DIV, r);    checkOutput("divWrite", r, 8'h00);

    $display("[TB] receive 0x5A");
    sendSerial(8'h5A, 1'b1);
    repeat (4) @(negedge clock);
    checkOutput("rxInt", {7'b0, intO}, 8'h01);
    readReg(ADDR_DATA, r);   checkOutput("rxData5A", r, 8'h5A);
    @(negedge clock);
    checkOutput("rxIntCleared", {7'b0, intO}, 8'h00);
    readReg(ADDR_STATUS, r); checkOutput("rxStatusAfterPop", r, 8'h04);

    $display("[TB] transmit 0xA5");
    writeReg(ADDR_DATA, 8'hA5);
    readReg(ADDR_STATUS, r); checkOutput("txHoldFull", r, 8'h00);
    readReg(ADDR_STATUS, r); checkOutput("txShifting", r, 8'h0C);
    repeat (8) @(negedge clock);
    for (int i = 0; i < 10; i++) begin
      checkOutput($sformatf("txA5Bit%0d", i), {7'b0, txd}, {7'b0, txPattern[i]});
      if (i < 9) repeat (16) @(negedge clock);
    end
    repeat (12) @(negedge clock);
    readReg(ADDR_STATUS, r); checkOutput("txDoneStatus", r, 8'h04);

    $display("[TB] overrun with 0x11 then 0x22");
    sendSerial(8'h11, 1'b1);
    sendSerial(8'h22, 1'b1);
    repeat (4) @(negedge clock);
    readReg(ADDR_STATUS, r); checkOutput("overrunStatus", r, 8'h07);
    readReg(ADDR_DATA, r);   checkOutput("overrunData", r, 8'h11);
    readReg(ADDR_STATUS, r); checkOutput("overrunCleared", r, 8'h04);

    $display("[TB] framing error and glitch");
    sendSerial(8'h55, 1'b0);
    repeat (4) @(negedge clock);
    checkOutput("frameErrInt", {7'b0, intO}, 8'h00);
    readReg(ADDR_STATUS, r); checkOutput("frameErrStatus", r, 8'h14);
    readReg(ADDR_STATUS, r); checkOutput("frameErrCleared", r, 8'h04);
    @(negedge clock);
    rxd = 1'b0;
    repeat (3) @(negedge clock);
    rxd = 1'b1;
    repeat (200) @(negedge clock);
    readReg(ADDR_STATUS, r); checkOutput("glitchStatus", r, 8'h04);
    checkOutput("glitchInt", {7'b0, intO}, 8'h00);

    $display("[TB] reset during transmit");
    writeReg(ADDR_CTRL, 8'h03);
    writeReg(ADDR_DATA, 8'h00);
    repeat (40) @(negedge clock);
    checkOutput("midTxLow", {7'b0, txd}, 8'h00);
    checkOutput("midTxInt", {7'b0, intO}, 8'h01);
    resetN = 1'b0;
    #1;
    checkOutput("midResetTxd", {7'b0, txd}, 8'h01);
    checkOutput("midResetInt", {7'b0, intO}, 8'h00);
    repeat (2) @(negedge clock);
    resetN = 1'b1;
    readReg(ADDR_STATUS, r); checkOutput("midResetStatus", r, 8'h04);
    readReg(ADDR_CTRL, r);   checkOutput("midResetCtrl", r, 8'h01);
    readReg(ADDR_DIV, r);    checkOutput("midResetDiv", r, 8'h1A);
    writeReg(ADDR_DIV, 8'h00);

    $display("[TB] echo loop 0x30..0x39");
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          sendSerial(8'h30 + 8'(i), 1'b1);
        end
      end
      begin
        logic [7:0] rv;
        int waited;
        for (int i = 0; i < 10; i++) begin
          waited = 0;
          while (intO !== 1'b1 && waited < 1000) begin
            @(negedge clock);
            waited++;
          end
          checkOutput("echoIntSeen", {7'b0, intO}, 8'h01);
          if (intO === 1'b1) begin
            readReg(ADDR_DATA, rv);
            checkOutput("echoRxData", rv, 8'h30 + 8'(i));
            writeReg(ADDR_DATA, rv);
          end
        end
      end
      begin
        logic [7:0] tb;
        logic found;
        for (int i = 0; i < 10; i++) begin
          captureTx(tb, found);
          checkOutput("echoTxFound", {7'b0, found}, 8'h01);
          checkOutput("echoTxData", tb, 8'h30 + 8'(i));
        end
      end
    join

    repeat (4) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_uart_serial.md
# wb_uart_serial

Byte-wide serial UART exposed as a zero-wait-state bus responder on the 2-bit-address, 8-bit-data `wb_*` bus driven by the miniterm FSMs. It sits between a bus initiator (e.g. the echo unit-test FSM) and the physical RX/TX pins. It deserialises incoming 8N1 frames into a one-byte receive register and serialises written bytes through a holding register plus a shifter. It raises `int_o` when enabled events are pending.

## Interface
- `DIV_RESET`, default 8'd26: reset value of the divisor register. The 16× oversample tick period is DIV+1 clocks.
- `wb_clk_i` in 1: single clock for the whole block.
- `rst_i` in 1: asynchronous, active-low reset; 0 = reset.
- `wb_cyc_i` in 1: access strobe. Each clock with `wb_cyc_i`=1 is exactly one access.
- `wb_we_i` in 1: 1 = write, 0 = read.
- `wb_addr_i` in 2: register select.
- `wb_datw_i` in 8: write data.
- `wb_datr_o` out 8: read data, combinational from `wb_addr_i`. Driven 8'h00 when `wb_cyc_i`=0.
- `int_o` out 1: interrupt, level; (rx_valid & rx_ie) | (tx_ready & tx_ie).
- `rxd_i` in 1: serial input, asynchronous to the clock.
- `txd_o` out 1: serial output, idle high.

## Operation
- Register map:
  - 0 DATA: read returns rx_data and pops it (rx_valid←0). A write loads the TX holding register.
  - 1 STATUS (read-only): bit0 rx_valid, bit1 rx_overrun, bit2 tx_ready (holding empty), bit3 tx_busy (shifter active), bit4 frame_err, bits7:5 = 0. A read clears bits 1 and 4.
  - 2 CTRL (R/W): bit0 rx_ie, bit1 tx_ie.
  - 3 DIV (R/W): divisor.
- Writes to STATUS are ignored.
- Tick generator: an 8-bit down-counter reloads from DIV and emits a 1-clock `tick` at 0. A write to DIV reloads the counter immediately.
- RX path: `rxd_i` passes through a 2-FF synchronizer (reset value 1). RX FSM states and transitions:
  - IDLE: a falling edge goes to START.
  - START: after 8 ticks, resample the line. If 0, go to DATA; if 1 (false start), go to IDLE.
  - DATA: 8 bits, LSB first, each sampled 16 ticks apart.
  - STOP: sampled 16 ticks later.
    - Stop=1 and rx_valid=0: store the byte and set rx_valid.
    - Stop=1 and rx_valid=1: discard the byte and set rx_overrun.
    - Stop=0: discard the byte and set frame_err.
  - Return to IDLE after STOP.
- TX path: a write to DATA with tx_ready=1 fills the holding register (tx_ready←0). A write with tx_ready=0 is dropped.
  - TX FSM IDLE: holding full → move the byte to the shifter on the same edge, set tx_ready and tx_busy, go to START.
  - START (txd 0), DATA ×8 (LSB first), STOP (txd 1): each lasts 16 ticks, timed from the next tick. Then IDLE.
  - Holding full at STOP end → reload directly, with no idle gap.
- Simultaneous events:
  - DATA read on the same edge that RX completes: the pop wins first, then the new byte loads. rx_valid stays 1 and no overrun is flagged.
  - DATA write on the same edge the shifter takes the holding byte: the write is accepted.
  - STATUS read on the same edge a flag sets: the flag stays set.

## Timing
- Reset values: `txd_o`=1, `int_o`=0, `wb_datr_o`=0, rx_valid/overrun/frame_err=0, tx_ready=1, tx_busy=0, CTRL=8'h01, DIV=DIV_RESET. Both FSMs go to IDLE.
- Reset mid-frame aborts both FSMs immediately (asynchronous) and `txd_o` returns to 1 without a clock.
- Read data is valid in the same cycle `wb_cyc_i`=1. There is no ack and no wait states.
- Side effects (pop, flag clear, register write) take effect at the clock edge that ends the access cycle.
- `int_o` is combinational from registers and updates one clock after the causing edge. It is guaranteed low the clock after a DATA read if no new byte completes and tx_ie=0.
- RX latency: rx_valid rises 1 clock after the stop-bit mid-sample tick.
- Bit period is 16×(DIV+1) clocks.

## Structure
- Package `uart_pkg`:
  - Address constants ADDR_DATA/STATUS/CTRL/DIV.
  - STATUS bit indices.
  - OVERSAMPLE=16.
  - RX/TX FSM state enums.
- One sub-module, `uart_rx_frame`: synchronizer, RX FSM and bit counter. It outputs a byte strobe plus frame_ok. The top level holds the bus registers, the TX path and the tick generator.

## Test plan
All scenarios use DIV=0, giving a 16-clock bit period.
- Reset with `rst_i`=0 asserted mid-TX-frame → `txd_o`=1 immediately; STATUS reads 8'h04; CTRL reads 8'h01.
- Drive frame 0x5A on `rxd_i` → `int_o`=1. A DATA read returns 0x5A, `int_o`=0 next clock, and STATUS then reads 8'h04.
- Write 0xA5 to DATA → `txd_o` shows 0,1,0,1,0,0,1,0,1,1 for 16 clocks each. STATUS bit2 returns to 1 one clock after the write.
- Two RX frames (0x11, 0x22) with no read in between → DATA reads 0x11 and STATUS reads 8'h07. A second STATUS read returns 8'h04.
- RX frame with stop bit 0 → rx_valid stays 0 and STATUS bit4=1. A 3-tick low glitch produces no start.
- Echo loop: an initiator reads DATA on `int_o` and writes it back. Frames 0x30..0x39 → identical bytes appear on `txd_o` in order.
